fetch_unit: RTL and testbench

- Parametrised instruction fetch front end. It replaces the single-cycle core's combinational PC/instruction-memory path with a decoupled, pipelined fetch.
- Owns the program counter and issues in-order requests to an instruction memory over a valid/ready handshake.
- Buffers returned instructions, with their PCs, in a DEPTH-entry FIFO feeding decode.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch front end: owns the PC, issues in-order memory
// requests under a credit limit and buffers returned words with their PCs.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam int unsigned     CW         = AW + 1;
    localparam int unsigned     CW1        = CW + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] PC_LSB     = XLEN'(1);
    localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CW:0]     CREDIT_MAX = CW1'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_count_q, drop_count_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [XLEN-1:0] pcbuf_q [DEPTH];
    logic [XLEN-1:0] pcbuf_d [DEPTH];

    logic [XLEN-1:0] redirect_target_s;
    logic            credit_ok_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_live_s;
    logic            push_s;
    logic            pop_s;
    logic            instr_valid_s;
    logic [CW-1:0]   fire_inc_s, rsp_dec_s, push_inc_s, pop_dec_s;

    // Handshake qualification; credits come from registered counts only.
    always_comb begin
        redirect_target_s = redirect_pc & ~PC_LSB;
        credit_ok_s       = ({1'b0, outstanding_q} + {1'b0, count_q}) < CREDIT_MAX;
        req_valid_s       = !reset && !redirect_valid && credit_ok_s;
        req_fire_s        = req_valid_s && imem_req_ready;
        // A response with nothing outstanding belongs to a pre-reset request.
        rsp_live_s        = imem_rsp_valid && (outstanding_q != CNT_ZERO);
        instr_valid_s     = (count_q != CNT_ZERO) && !redirect_valid;
        pop_s             = instr_valid_s && instr_ready;
        push_s            = rsp_live_s && !redirect_valid && (drop_count_q == CNT_ZERO);
        fire_inc_s        = req_fire_s ? CNT_ONE : CNT_ZERO;
        rsp_dec_s         = rsp_live_s ? CNT_ONE : CNT_ZERO;
        push_inc_s        = push_s ? CNT_ONE : CNT_ZERO;
        pop_dec_s         = pop_s ? CNT_ONE : CNT_ZERO;
    end

    // Next-state for PCs, counters and the instruction buffer.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_count_d  = drop_count_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        data_d        = data_q;
        pcbuf_d       = pcbuf_q;
        outstanding_d = outstanding_q + fire_inc_s - rsp_dec_s;
        if (redirect_valid) begin
            fetch_pc_d   = redirect_target_s;
            rsp_pc_d     = redirect_target_s;
            // Every request still unreturned after this cycle is stale.
            drop_count_d = outstanding_q - rsp_dec_s;
            count_d      = CNT_ZERO;
            rd_ptr_d     = wr_ptr_q;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_live_s && (drop_count_q != CNT_ZERO)) begin
                drop_count_d = drop_count_q - CNT_ONE;
            end else begin
                drop_count_d = drop_count_q;
            end
            if (push_s) begin
                data_d[wr_ptr_q]  = imem_rsp_data;
                pcbuf_d[wr_ptr_q] = rsp_pc_q;
                wr_ptr_d          = wr_ptr_q + PTR_ONE;
                rsp_pc_d          = rsp_pc_q + PC_STEP;
            end else begin
                wr_ptr_d = wr_ptr_q;
                rsp_pc_d = rsp_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + push_inc_s - pop_dec_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= CNT_ZERO;
            drop_count_q  <= CNT_ZERO;
            count_q       <= CNT_ZERO;
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= 32'h0000_0000;
                pcbuf_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            data_q        <= data_d;
            pcbuf_q       <= pcbuf_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = instr_valid_s;
    assign instr          = data_q[rd_ptr_q];
    assign instr_pc       = pcbuf_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a queue-based model of the fetch stream and
// a fixed-latency memory, compared every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        inflight[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch_pc = RPC;
    logic [31:0] m_rsp_pc   = RPC;
    int          cyc = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ (a >> 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                        input bit rq_rdy, input bit ir);
        bit          rsp, exp_rv, exp_iv;
        logic [31:0] tgt;
        req_t        r;
        rsp = (inflight.size() > 0) && (inflight[0].due <= cyc);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        instr_ready    = ir;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(inflight[0].addr) : $urandom();
        #1;
        exp_rv = !rst && !rv && ((inflight.size() + fifo_m.size()) < DEPTH);
        exp_iv = (fifo_m.size() != 0) && !rv;
        s_rv = imem_req_valid; s_iv = instr_valid; s_addr = imem_req_addr;
        s_pc = instr_pc; s_instr = instr;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
        if (!rst) begin
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
            if (exp_iv) begin
                chk("instr", instr, fifo_m[0].data);
                chk("instr_pc", instr_pc, fifo_m[0].pc);
            end
        end
        if (rst) begin
            inflight.delete();
            fifo_m.delete();
            m_fetch_pc = RPC;
            m_rsp_pc   = RPC;
        end else begin
            if (exp_iv && ir) void'(fifo_m.pop_front());
            if (rsp) begin
                r = inflight.pop_front();
                if (!rv && !r.stale) begin
                    fifo_m.push_back('{pc: m_rsp_pc, data: memword(r.addr)});
                    m_rsp_pc = m_rsp_pc + 32'd4;
                end
            end
            if (rv) begin
                tgt = rpc & 32'hFFFF_FFFE;
                fifo_m.delete();
                foreach (inflight[k]) inflight[k].stale = 1'b1;
                m_fetch_pc = tgt;
                m_rsp_pc   = tgt;
            end else if (exp_rv && rq_rdy) begin
                inflight.push_back('{addr: m_fetch_pc, due: cyc + lat, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        int fires;
        bit found;
        logic [31:0] first_pc, second_pc;
        @(negedge clk);

        // Reset then stream with a single-cycle memory.
        lat = 1;
        do_reset(2);
        step(0, 0, 0, 1, 1);
        chk("rst_req_valid", {31'b0, s_rv}, 32'd1);
        chk("rst_req_addr", s_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, s_iv}, 32'd0);
        step(0, 0, 0, 1, 1);
        chk("stream_c1_valid", {31'b0, s_iv}, 32'd0);
        step(0, 0, 0, 1, 1);
        chk("stream_c2_valid", {31'b0, s_iv}, 32'd1);
        chk("stream_c2_pc", s_pc, 32'h0);
        step(0, 0, 0, 1, 1);
        chk("stream_c3_pc", s_pc, 32'h4);
        chk("stream_c3_instr", s_instr, memword(32'h4));
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1);
            chk("stream_steady", {31'b0, s_iv}, 32'd1);
        end

        // Backpressure until full, then release one slot.
        do_reset(1);
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 0);
            fires += int'(s_rv);
        end
        chk("bp_fires", fires, 32'd4);
        chk("bp_req_dropped", {31'b0, s_rv}, 32'd0);
        step(0, 0, 0, 1, 1);
        chk("bp_pop_cycle_req", {31'b0, s_rv}, 32'd0);
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            fires += int'(s_rv);
        end
        chk("bp_refill_fires", fires, 32'd1);

        // Redirect with three requests in flight on a slow memory.
        lat = 3;
        do_reset(1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h100, 1, 1);
        found = 0; first_pc = 32'hX; second_pc = 32'hX;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 0, 1, 1);
            if (s_iv) begin
                found = 1;
                first_pc = s_pc;
                step(0, 0, 0, 1, 1);
                second_pc = s_pc;
            end
        end
        chk("redir_found", {31'b0, found}, 32'd1);
        chk("redir_first_pc", first_pc, 32'h100);
        chk("redir_second_pc", second_pc, 32'h104);

        // Redirect coinciding with a response, two outstanding.
        lat = 2;
        do_reset(1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h300, 1, 1);
        chk("rr_drop_count", {29'b0, dut.drop_count_q}, 32'd1);
        step(0, 0, 0, 1, 1);
        chk("rr_empty_c1", {31'b0, s_iv}, 32'd0);
        chk("rr_drop_done", {29'b0, dut.drop_count_q}, 32'd0);
        step(0, 0, 0, 1, 1);
        chk("rr_empty_c2", {31'b0, s_iv}, 32'd0);

        // Memory stall at 0x20.
        lat = 1;
        do_reset(1);
        for (int k = 0; k < 20 && m_fetch_pc != 32'h20; k++) step(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            chk("stall_addr", s_addr, 32'h20);
        end
        step(0, 0, 0, 1, 1);
        chk("stall_release_addr", s_addr, 32'h20);
        step(0, 0, 0, 1, 1);
        chk("stall_next_addr", s_addr, 32'h24);

        // Misaligned jalr target, then reset with a full buffer.
        step(0, 1, 32'h203, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("jalr_addr", s_addr, 32'h202);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        chk("full_valid", {31'b0, s_iv}, 32'd1);
        chk("full_no_req", {31'b0, s_rv}, 32'd0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("midrst_instr_valid", {31'b0, s_iv}, 32'd0);
        chk("midrst_addr", s_addr, RPC);
        chk("midrst_instr", s_instr, 32'h0);
        chk("midrst_pc", s_pc, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 1) begin
                lat = $urandom_range(1, 3);
                do_reset(1);
            end else begin
                step(0, $urandom_range(0, 99) < 5, 32'($urandom_range(0, 4095)),
                     $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
